// File: rtl/mux_share_pkg.sv
// Shared encodings for the two-requester mux-share arbiter.
package mux_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/mux_share_arbiter_mux2_w.sv
// DATA_W-wide combinational 2:1 mux feeding the arbiter output register.
module mux2_w #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin two-requester arbiter with bounded hold driving a shared 2:1 datapath.
// Optional per-requester grant-entry counters under MUX_SHARE_ARBITER_STATS_EN.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid
`ifdef MUX_SHARE_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                last_q, last_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   mux_y;
  logic                word_ok;
  logic                enter_g0, enter_g1;

  mux2_w #(.DATA_W(DATA_W)) u_mux (
    .a   (data0),
    .b   (data1),
    .sel (sel_q),
    .y   (mux_y)
  );

  // Release takes priority over forced rotation; rotation only when the other side waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_G0 : ST_G1;
        else if (req0)     state_d = ST_G0;
        else if (req1)     state_d = ST_G1;
      end
      ST_G0: begin
        if (!req0)         state_d = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST))
                           state_d = ST_G1;
      end
      ST_G1: begin
        if (!req1)         state_d = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST))
                           state_d = ST_G0;
      end
      default:             state_d = ST_IDLE;
    endcase
  end

  assign enter_g0 = (state_d == ST_G0) && (state_q != ST_G0);
  assign enter_g1 = (state_d == ST_G1) && (state_q != ST_G1);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;
    if (state_d == ST_IDLE || state_d != state_q)
      hold_cnt_d = '0;
    else if (hold_cnt_q != HOLD_SAT)
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    if (enter_g0) last_d = 1'b0;
    if (enter_g1) last_d = 1'b1;
    // In IDLE the select keeps pointing at the previous owner.
    if (state_d == ST_G0) sel_d = 1'b0;
    if (state_d == ST_G1) sel_d = 1'b1;
  end

  assign word_ok = ((state_q == ST_G0) && req0) || ((state_q == ST_G1) && req1);

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (word_ok) begin
      data_out_d  = mux_y;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt0      = (state_q == ST_G0);
  assign gnt1      = (state_q == ST_G1);
  assign sel       = sel_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

`ifdef MUX_SHARE_ARBITER_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Entry counters saturate; a forced rotation is an entry for the new owner.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (enter_g0 && grant_cnt0_q != '1) grant_cnt0_d = grant_cnt0_q + STAT_W'(1);
    if (enter_g1 && grant_cnt1_q != '1) grant_cnt1_d = grant_cnt1_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter (MAX_HOLD=4): grant checks inline, data words via scoreboard.
module tb_mux_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] data_out;
`ifdef MUX_SHARE_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  mux_share_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .data_out  (data_out),
    .out_valid (out_valid)
`ifdef MUX_SHARE_ARBITER_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_idle_outs(input string nm, input logic sel_req);
    chk({nm, "_gnt0"}, gnt0, 1'b0);
    chk({nm, "_gnt1"}, gnt1, 1'b0);
    chk({nm, "_sel"}, sel, sel_req);
    chk({nm, "_valid"}, out_valid, 1'b0);
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got %0h, expected no word", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL sb_word: got %0h, expected %0h", data_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit own_tab[1:12];
    own_tab = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; data0 = 8'h00; data1 = 8'h00;
    repeat (2) @(negedge clk);
    chk_idle_outs("reset", 1'b0);
    chk("reset_data", data_out, 8'h00);

    rst_n = 1'b1; data0 = 8'h10; data1 = 8'h80;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("rr_gnt0", gnt0, own_tab[c] == 1'b0);
      chk("rr_gnt1", gnt1, own_tab[c] == 1'b1);
      chk("rr_sel", sel, own_tab[c]);
      data0 = 8'(8'h10 + c);
      data1 = 8'(8'h80 + c);
      exp_q.push_back(own_tab[c] ? data1 : data0);
    end

    @(negedge clk);
    chk("rr12_gnt0", gnt0, 1'b1);
    req0 = 1'b0; data0 = 8'hEE; data1 = 8'hA5;

    @(negedge clk);
    chk("handoff_gnt0", gnt0, 1'b0);
    chk("handoff_gnt1", gnt1, 1'b1);
    chk("handoff_sel", sel, 1'b1);
    chk("handoff_valid", out_valid, 1'b0);
    exp_q.push_back(8'hA5);

    @(negedge clk);
    req1 = 1'b0;

    @(negedge clk);
    chk_idle_outs("idle_after_g1", 1'b1);
    req0 = 1'b1; data0 = 8'h3C;

    @(negedge clk);
    chk("single0_gnt0", gnt0, 1'b1);
    chk("single0_sel", sel, 1'b0);
    exp_q.push_back(8'h3C);

    @(negedge clk);
    req0 = 1'b0;

    @(negedge clk);
    chk_idle_outs("idle_after_g0", 1'b0);
    req1 = 1'b1; data0 = 8'h55; data1 = 8'hA5;

    @(negedge clk);
    chk("single1_gnt1", gnt1, 1'b1);
    chk("single1_gnt0", gnt0, 1'b0);
    chk("single1_sel", sel, 1'b1);
    chk("single1_valid", out_valid, 1'b0);
    exp_q.push_back(8'hA5);

    @(negedge clk);
    exp_q.push_back(8'hA5);

    @(negedge clk);
    chk("midrst_pre_gnt1", gnt1, 1'b1);
    rst_n = 1'b0; req0 = 1'b1;

    @(negedge clk);
    chk_idle_outs("midrst", 1'b0);
    chk("midrst_data", data_out, 8'h00);
    rst_n = 1'b1; data0 = 8'h77; data1 = 8'h88;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_gnt0", gnt0, 1'b1);
      chk("post_rst_gnt1", gnt1, 1'b0);
      exp_q.push_back(8'h77);
    end

    @(negedge clk);
    chk("post_rst_rot_gnt0", gnt0, 1'b0);
    chk("post_rst_rot_gnt1", gnt1, 1'b1);
    req0 = 1'b0; req1 = 1'b0;

    @(negedge clk);
    chk_idle_outs("final_idle", 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

`ifdef MUX_SHARE_ARBITER_STATS_EN
    chk("stats_cnt0", grant_cnt0, 16'd1);
    chk("stats_cnt1", grant_cnt1, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
